// File: rtl/clkdiv_pkg.sv
// clkdiv_multi shared types and defaults.
// Divider mode encoding plus reset constants for dividers and LFSR.
package clkdiv_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_LFSR_W = 16;

    // Divide registers reset to all-ones at any counter width.
    localparam bit DIV_RST_FILL = 1'b1;

    localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEF_LFSR_SEED = 16'h5555;

endpackage

// File: rtl/clkdiv_multi_if.sv
// Channel configuration bus for clkdiv_multi.
// Master writes one channel's shadow divide/mode per cfg_we cycle.
interface clkdiv_multi_if #(
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_mode;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_div,
        output cfg_mode
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_div,
        input cfg_mode
    );

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: up-counter, active/shadow divide and mode,
// pending flag, registered divided output and terminal strobe.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DIV_RST = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             run,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  mode_e            wr_mode,
    output logic             div_out,
    output logic             div_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_shd_q, div_shd_d;
    mode_e            mode_act_q, mode_act_d;
    mode_e            mode_shd_q, mode_shd_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             term;
    mode_e            nxt_mode;

    // Next-state: ena freezes everything except shadow writes.
    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        mode_act_d = mode_act_q;
        div_shd_d  = div_shd_q;
        mode_shd_d = mode_shd_q;
        pend_d     = pend_q;
        out_d      = out_q;
        tick_d     = 1'b0;
        term       = (cnt_q == div_act_q);
        nxt_mode   = pend_q ? mode_shd_q : mode_act_q;
        if (ena) begin
            if (!run) begin
                cnt_d = '0;
                out_d = 1'b0;
                if (pend_q) begin
                    div_act_d  = div_shd_q;
                    mode_act_d = mode_shd_q;
                    pend_d     = 1'b0;
                end
            end else if (term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pend_q) begin
                    div_act_d  = div_shd_q;
                    mode_act_d = mode_shd_q;
                    pend_d     = 1'b0;
                end
                // Entering toggle from pulse restarts low.
                if (nxt_mode == MODE_PULSE) begin
                    out_d = 1'b1;
                end else if (mode_act_q == MODE_PULSE) begin
                    out_d = 1'b0;
                end else begin
                    out_d = !out_q;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (mode_act_q == MODE_PULSE) begin
                    out_d = 1'b0;
                end
            end
        end
        // Write lands after the apply, so it waits for the next one.
        if (wr) begin
            div_shd_d  = wr_div;
            mode_shd_d = wr_mode;
            pend_d     = 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_RST;
            div_shd_q  <= DIV_RST;
            mode_act_q <= MODE_TOGGLE;
            mode_shd_q <= MODE_TOGGLE;
            pend_q     <= 1'b0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_shd_q  <= div_shd_d;
            mode_act_q <= mode_act_d;
            mode_shd_q <= mode_shd_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
        end
    end

    assign div_out  = out_q;
    assign div_tick = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with a Fibonacci LFSR
// that steps every enabled cycle or on channel-0 terminal strobes.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int                CNT_W     = DEF_CNT_W,
    parameter int                N_CH      = 4,
    parameter int                CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter logic [CNT_W-1:0]  DIV_RST   = {CNT_W{DIV_RST_FILL}},
    parameter int                LFSR_W    = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
    parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    clkdiv_multi_if.slave     cfg,
    input  logic [N_CH-1:0]   ch_en,
    output logic [N_CH-1:0]   div_out,
    output logic [N_CH-1:0]   div_tick,
    input  logic              lfsr_load,
    input  logic [LFSR_W-1:0] lfsr_seed,
    input  logic              lfsr_step_sel,
    output logic [LFSR_W-1:0] lfsr_out
);

    logic [CH_W-1:0]   sel;
    logic [N_CH-1:0]   wr_sel;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              lfsr_step;

    assign sel = cfg.cfg_ch;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no instance.
        assign wr_sel[i] = cfg.cfg_we && (int'(sel) == i);

        clkdiv_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .run      (ch_en[i]),
            .wr       (wr_sel[i]),
            .wr_div   (cfg.cfg_div),
            .wr_mode  (mode_e'(cfg.cfg_mode)),
            .div_out  (div_out[i]),
            .div_tick (div_tick[i])
        );
    end

    // LFSR next state: load beats step; zero seed would lock up.
    always_comb begin
        lfsr_step = ena && (lfsr_step_sel ? div_tick[0] : 1'b1);
        lfsr_d    = lfsr_q;
        if (lfsr_load) begin
            lfsr_d = (lfsr_seed == '0) ? LFSR_SEED : lfsr_seed;
        end else if (lfsr_step) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: directed and random stimulus,
// expectations from a countdown-based reference model.
module tb_clkdiv_multi;
    import clkdiv_pkg::*;

    localparam int N   = 3;
    localparam int CW  = 16;
    localparam int CHW = 2;
    localparam int LW  = 16;

    typedef struct {
        logic [N-1:0]  out;
        logic [N-1:0]  tick;
        logic [LW-1:0] lfsr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena;
    logic [N-1:0]  ch_en;
    logic [N-1:0]  div_out;
    logic [N-1:0]  div_tick;
    logic          lfsr_load;
    logic [LW-1:0] lfsr_seed;
    logic          lfsr_step_sel;
    logic [LW-1:0] lfsr_out;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: cycles left until terminal, toggle level.
    int unsigned m_dact[N];
    int unsigned m_dshd[N];
    int unsigned m_left[N];
    bit          m_mact[N];
    bit          m_mshd[N];
    bit          m_pend[N];
    bit          m_out[N];
    bit          m_tick[N];
    int unsigned m_lfsr;

    always #5 clk = ~clk;

    clkdiv_multi_if #(.CNT_W(CW), .CH_W(CHW)) cfg_if ();

    clkdiv_multi #(
        .CNT_W (CW),
        .N_CH  (N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .cfg           (cfg_if.slave),
        .ch_en         (ch_en),
        .div_out       (div_out),
        .div_tick      (div_tick),
        .lfsr_load     (lfsr_load),
        .lfsr_seed     (lfsr_seed),
        .lfsr_step_sel (lfsr_step_sel),
        .lfsr_out      (lfsr_out)
    );

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_dact[c] = 65535;
            m_dshd[c] = 65535;
            m_left[c] = 65535;
            m_mact[c] = 1'b0;
            m_mshd[c] = 1'b0;
            m_pend[c] = 1'b0;
            m_out[c]  = 1'b0;
            m_tick[c] = 1'b0;
        end
        m_lfsr = 32'h5555;
    endfunction

    function automatic void model_apply(int c);
        if (m_pend[c]) begin
            m_dact[c] = m_dshd[c];
            m_mact[c] = m_mshd[c];
            m_pend[c] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit          prev_tick0;
        bit          was_pulse;
        int unsigned fb;
        prev_tick0 = m_tick[0];
        for (int c = 0; c < N; c++) begin
            if (!ena) begin
                m_tick[c] = 1'b0;
            end else if (!ch_en[c]) begin
                m_out[c]  = 1'b0;
                m_tick[c] = 1'b0;
                model_apply(c);
                m_left[c] = m_dact[c];
            end else if (m_left[c] == 0) begin
                was_pulse = m_mact[c];
                model_apply(c);
                m_tick[c] = 1'b1;
                m_left[c] = m_dact[c];
                if (m_mact[c]) m_out[c] = 1'b1;
                else if (was_pulse) m_out[c] = 1'b0;
                else m_out[c] = !m_out[c];
            end else begin
                m_left[c] = m_left[c] - 1;
                m_tick[c] = 1'b0;
                if (m_mact[c]) m_out[c] = 1'b0;
            end
        end
        if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) < N) begin
            m_dshd[cfg_if.cfg_ch] = int'(cfg_if.cfg_div);
            m_mshd[cfg_if.cfg_ch] = cfg_if.cfg_mode;
            m_pend[cfg_if.cfg_ch] = 1'b1;
        end
        if (lfsr_load) begin
            m_lfsr = (lfsr_seed == 0) ? 32'h5555 : int'(lfsr_seed);
        end else if (ena && (lfsr_step_sel ? prev_tick0 : 1'b1)) begin
            fb = $countones(m_lfsr & 32'hB400) % 2;
            m_lfsr = (m_lfsr * 2 + fb) % 65536;
        end
    endfunction

    // Predict the outputs after the coming posedge, then wait a cycle.
    task automatic step_cyc();
        exp_t e;
        if (!rst_n) model_reset();
        else model_step();
        for (int c = 0; c < N; c++) begin
            e.out[c]  = m_out[c];
            e.tick[c] = m_tick[c];
        end
        e.lfsr = LW'(m_lfsr);
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) step_cyc();
    endtask

    task automatic cfg_write(int ch, int d, bit md);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_ch   = CHW'(ch);
        cfg_if.cfg_div  = CW'(d);
        cfg_if.cfg_mode = md;
        step_cyc();
        cfg_if.cfg_we = 1'b0;
    endtask

    // Reset pulse between edges: only an asynchronous reset sees it.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("div_out", 32'(div_out), 32'(e.out));
                check("div_tick", 32'(div_tick), 32'(e.tick));
                check("lfsr_out", 32'(lfsr_out), 32'(e.lfsr));
            end
        end
    end

    initial begin
        int r;
        ena             = 1'b1;
        ch_en           = '0;
        lfsr_load       = 1'b0;
        lfsr_seed       = '0;
        lfsr_step_sel   = 1'b0;
        cfg_if.cfg_we   = 1'b0;
        cfg_if.cfg_ch   = '0;
        cfg_if.cfg_div  = '0;
        cfg_if.cfg_mode = 1'b0;
        @(negedge clk);
        run(3);
        rst_n = 1'b1;
        run(3);

        cfg_write(0, 3, 1'b0);
        step_cyc();
        ch_en[0] = 1'b1;
        run(20);

        cfg_write(1, 1, 1'b1);
        step_cyc();
        ch_en[1] = 1'b1;
        run(9);
        cfg_write(1, 5, 1'b1);
        run(20);

        cfg_write(2, 0, 1'b0);
        step_cyc();
        ch_en[2] = 1'b1;
        run(5);
        cfg_write(2, 0, 1'b1);
        run(5);
        ena = 1'b0;
        run(3);
        ena = 1'b1;
        ch_en[2] = 1'b0;
        run(2);
        ch_en[2] = 1'b1;

        lfsr_seed = '0;
        lfsr_load = 1'b1;
        step_cyc();
        lfsr_load = 1'b0;
        run(2);
        ena = 1'b0;
        lfsr_seed = 16'h1234;
        lfsr_load = 1'b1;
        step_cyc();
        lfsr_load = 1'b0;
        run(2);
        ena = 1'b1;

        lfsr_step_sel = 1'b1;
        run(16);
        lfsr_step_sel = 1'b0;

        cfg_write(3, 1, 1'b1);
        run(4);

        for (int k = 0; k < 20 && m_left[0] != 0; k++) step_cyc();
        cfg_write(0, 2, 1'b0);
        run(12);

        repeat (3000) begin
            ena = ($urandom_range(0, 9) != 0);
            cfg_if.cfg_we   = ($urandom_range(0, 4) == 0);
            cfg_if.cfg_ch   = CHW'($urandom_range(0, 3));
            r = $urandom_range(0, 15);
            cfg_if.cfg_div  = (r == 15) ? 16'hFFFF : CW'(r % 8);
            cfg_if.cfg_mode = 1'($urandom_range(0, 1));
            for (int c = 0; c < N; c++) ch_en[c] = ($urandom_range(0, 15) != 0);
            lfsr_load = ($urandom_range(0, 40) == 0);
            lfsr_seed = ($urandom_range(0, 1) != 0) ? 16'h0 : LW'($urandom);
            if ($urandom_range(0, 99) == 0) lfsr_step_sel = ~lfsr_step_sel;
            if ($urandom_range(0, 599) == 0) async_reset();
            step_cyc();
        end

        @(posedge clk);
        #2;
        check("sbq_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
Parametrised multi-channel programmable clock divider with an attached configurable Fibonacci LFSR. It is the next-generation divider/random-source block for tile designs. Each channel has its own divide value and mode (50% toggle or one-cycle strobe). Divide changes are glitch-free: they are written to a shadow register and applied only at a terminal count. The LFSR has parametrised width and taps, a seed-load port, and can step either every enabled cycle or on channel-0 strobes.

Parameters:
- CNT_W, 16, counter / divide-value width.
- N_CH, 4, number of divider channels (≥1).
- CH_W, $clog2(N_CH) min 1, channel-select width (derived).
- DIV_RST, all-ones, reset value of every active and shadow divide register.
- LFSR_W, 16, LFSR width.
- LFSR_TAPS, 16'hB400, tap mask; feedback = XOR-reduce(lfsr & LFSR_TAPS).
- LFSR_SEED, 16'h5555, reset seed and zero-lockup replacement value (must be nonzero).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, global enable; low freezes counters, outputs and LFSR.
- cfg_we, input, 1, write strobe for channel configuration.
- cfg_ch, input, CH_W, target channel.
- cfg_div, input, CNT_W, divide value D; period is D+1 clocks per terminal count.
- cfg_mode, input, 1, 0 = toggle, 1 = pulse.
- ch_en, input, N_CH, per-channel run enable.
- div_out, output, N_CH, divided clock (toggle mode) or strobe (pulse mode); registered.
- div_tick, output, N_CH, one-cycle terminal-count strobe; registered.
- lfsr_load, input, 1, load seed.
- lfsr_seed, input, LFSR_W, seed value.
- lfsr_step_sel, input, 1, 0 = step every ena cycle, 1 = step when div_tick[0] is high.
- lfsr_out, output, LFSR_W, LFSR state; registered.

Behaviour:
- Reset:
  - cnt = 0; div_act = div_shd = DIV_RST; mode_act = mode_shd = 0; pending = 0.
  - div_out = 0; div_tick = 0; lfsr_out = LFSR_SEED.
- Config write (cfg_we=1):
  - Writes div_shd/mode_shd of channel cfg_ch and sets its pending flag. Accepted regardless of ena.
  - cfg_ch ≥ N_CH: write ignored.
  - A later write before the apply point overwrites the shadow; last write wins.
- Channel run (ena=1 and ch_en[i]=1):
  - cnt != div_act: cnt+1, div_tick=0.
  - cnt == div_act (terminal): cnt=0, div_tick=1 for one cycle.
    - Mode 0: div_out toggles.
    - If pending: div_act/mode_act ← shadow, pending=0. The new value governs the very next count.
- Mode 0: div_out period = 2·(D+1) clocks, 50% duty. D=0 gives period 2.
- Mode 1: div_out = div_tick (same register timing). D=0 makes div_out constant 1 while running.
- Mode change applied at terminal: div_out is forced to 0 in the same cycle entering mode 0, so the first toggle goes high.
- Channel disabled (ch_en[i]=0):
  - cnt=0, div_out=0, div_tick=0.
  - Pending shadow is applied immediately, next cycle.
  - Re-enable starts a full count from 0.
- ena=0: all cnt, div_out, div_tick (forced 0), pending applies and LFSR are held. Shadow writes still land.
- cfg_we to a channel in the same cycle as its terminal: the terminal applies the old shadow state (if any was pending). The new write stays pending until the next terminal.
- div_act lowered below the current cnt can only happen at a terminal, where cnt=0, so no wrap-around past D is possible.
- LFSR:
  - Shift left; bit0 ← feedback. Steps when ena=1 and (lfsr_step_sel ? div_tick[0] : 1).
  - lfsr_load has priority over stepping and is honoured even when ena=0. It loads lfsr_seed, or LFSR_SEED if lfsr_seed==0 (zero-lockup guard).
- Asynchronous reset mid-count returns everything to reset values immediately. Pending writes are lost.

Decomposition:
- Package clkdiv_pkg holds:
  - mode enum (MODE_TOGGLE=0, MODE_PULSE=1);
  - default LFSR_TAPS and LFSR_SEED constants;
  - the DIV_RST default.
- Sub-module clkdiv_chan contains one channel: counter, active/shadow registers, pending flag, outputs. It is instantiated N_CH times via generate.
- The LFSR stays inline in clkdiv_multi.

Test Plan:
- Reset, write ch0 D=3 mode 0, ch_en=1, ena=1 -> div_tick[0] high every 4th cycle; div_out[0] toggles at each tick; period 8.
- While running ch1 D=1 mode 1, write D=5 mid-count -> old 2-cycle strobe spacing continues until the next tick, then spacing becomes 6; no short or long pulse.
- D=0 on ch2, mode 0 then mode 1 -> toggles every cycle; after the mode-change terminal, div_out constant 1; ena=0 holds both outputs; ch_en=0 forces 0.
- LFSR after reset, lfsr_step_sel=0 -> 0x5555, 0xAAAA, 0x5554 on successive cycles. lfsr_load with seed 0 -> 0x5555; lfsr_load with seed 0x1234 while ena=0 -> 0x1234.
- lfsr_step_sel=1 with ch0 D=3 -> LFSR changes only in the cycle after each div_tick[0], i.e. every 4 cycles.
- cfg_we with cfg_ch=N_CH (when N_CH is not a power of two) -> no channel changes. Simultaneous write and terminal on ch0 -> new D is applied at the following terminal.
